stage_timer: RTL

Parametrised per-stage countdown timer for the typing game. A prescaler turns the system clock into game ticks, and a per-stage limit is loaded whenever play starts or the stage changes. The block counts down, reports the remaining time, and raises `pause` when time runs out. It sits between the stage/score controller (which drives `stage` and `start`) and the word-scroll/input logic (which stops on `pause`). It generalises the single boss-stage timer to any set of stages, with hold/resume and a visible remaining count.

---
 rtl/stage_timer_pkg.sv | 22 ++
 rtl/tick_gen.sv | 29 ++
 rtl/stage_timer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/stage_timer_pkg.sv
// Shared types and helpers for the per-stage countdown timer.
// The state enum and the stage-limit lookup are used by stage_timer.
package stage_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HOLD,
    ST_EXPIRED
  } st_state_t;

  // Tick budget for a stage; the caller truncates to the counter width.
  function automatic logic [31:0] stage_limit(
    input logic [31:0] stage,
    input logic [31:0] boss_stage,
    input logic [31:0] boss_limit,
    input logic [31:0] normal_limit
  );
    return (stage == boss_stage) ? boss_limit : normal_limit;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Game-tick prescaler: counts 0..DIV-1 while en is high, clr forces 0.
// wrap is high on the last count, i.e. the counter rolls over on this edge if en.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic wrap
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt_reg;

  assign wrap = (cnt_reg == W'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= wrap ? '0 : cnt_reg + W'(1);
    end
  end

endmodule

// File: rtl/stage_timer.sv
// Per-stage countdown timer: loads a stage budget, counts game ticks down, raises pause on expiry.
// Optional warn output is built only when STAGE_TIMER_WARN_EN is defined.
module stage_timer
  import stage_timer_pkg::*;
#(
  parameter int          CLK_DIV      = 2500000,
  parameter int          STAGE_W      = 5,
  parameter int          CNT_W        = 6,
  parameter logic [31:0] TIMED_MASK   = 32'h0000_0008,
  parameter int          BOSS_STAGE   = 3,
  parameter int          BOSS_LIMIT   = 10,
  parameter int          NORMAL_LIMIT = 30,
  parameter int          WARN_LEVEL   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [STAGE_W-1:0] stage,
  input  logic               hold,
  output logic               pause,
  output logic [CNT_W-1:0]   remaining,
  output logic               tick,
  output logic               expired
`ifdef STAGE_TIMER_WARN_EN
  ,
  output logic               warn
`endif
);

  st_state_t            state_reg, state_next;
  logic [CNT_W-1:0]     remaining_reg, remaining_next;
  logic [STAGE_W-1:0]   stage_reg;
  logic                 pause_reg, pause_next;
  logic                 tick_reg, tick_next;
  logic                 expired_reg, expired_next;
  logic                 presc_en, presc_clr, presc_wrap;
  logic                 timed, stage_chg;
  logic [CNT_W-1:0]     lim;

  assign timed     = start && TIMED_MASK[stage];
  assign stage_chg = (stage != stage_reg);
  assign lim       = CNT_W'(stage_limit(32'(stage), 32'(BOSS_STAGE), 32'(BOSS_LIMIT),
                                        32'(NORMAL_LIMIT)));

  tick_gen #(
    .DIV(CLK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (presc_en),
    .clr  (presc_clr),
    .wrap (presc_wrap)
  );

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    tick_next      = 1'b0;
    expired_next   = 1'b0;
    presc_en       = 1'b0;
    presc_clr      = 1'b0;

    if (!timed) begin
      state_next     = ST_IDLE;
      remaining_next = '0;
      presc_clr      = 1'b1;
    end else if (state_reg == ST_IDLE || stage_chg) begin
      // Fresh load; a stage change outranks hold and any coincident wrap.
      remaining_next = lim;
      presc_clr      = 1'b1;
      if (lim == '0) begin
        state_next   = ST_EXPIRED;
        expired_next = 1'b1;
      end else begin
        state_next   = ST_RUN;
      end
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (hold) begin
            state_next = ST_HOLD;
          end else begin
            presc_en = 1'b1;
            if (presc_wrap && remaining_reg != '0) begin
              tick_next      = 1'b1;
              remaining_next = remaining_reg - CNT_W'(1);
              if (remaining_reg == CNT_W'(1)) begin
                state_next   = ST_EXPIRED;
                expired_next = 1'b1;
              end
            end
          end
        end
        ST_HOLD: begin
          if (!hold) state_next = ST_RUN;
        end
        ST_EXPIRED: begin
          remaining_next = '0;
          presc_clr      = 1'b1;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end

    pause_next = (state_next != ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      remaining_reg <= '0;
      stage_reg     <= '0;
      pause_reg     <= 1'b1;
      tick_reg      <= 1'b0;
      expired_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      stage_reg     <= stage;
      pause_reg     <= pause_next;
      tick_reg      <= tick_next;
      expired_reg   <= expired_next;
    end
  end

  assign pause     = pause_reg;
  assign remaining = remaining_reg;
  assign tick      = tick_reg;
  assign expired   = expired_reg;

`ifdef STAGE_TIMER_WARN_EN
  logic warn_reg, warn_next;

  assign warn_next = (state_next == ST_RUN || state_next == ST_HOLD) &&
                     (remaining_next != '0) &&
                     (remaining_next <= CNT_W'(WARN_LEVEL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) warn_reg <= 1'b0;
    else        warn_reg <= warn_next;
  end

  assign warn = warn_reg;
`endif

endmodule
